// File: rtl/id_stage_pipelined.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : id_stage_pipelined                                            |
// | Purpose  : MIPS32 decode stage with EX/MEM bypass, load-use detection,   |
// |            jump/branch resolution in ID and an ID/EX pipeline register.   |
// | Option   : ID_COND_BRANCH_EN enables BEQ/BNE decode.                      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module id_stage_pipelined #(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        inst_i,
  input  logic [DATA_W-1:0]  pc_i,
  input  logic               id_valid_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [DATA_W-1:0]  readData1_i,
  input  logic [DATA_W-1:0]  readData2_i,
  output logic [4:0]         readAddr1_o,
  output logic [4:0]         readAddr2_o,
  output logic               readEnable1_o,
  output logic               readEnable2_o,
  input  logic [DATA_W-1:0]  EX_writeData_i,
  input  logic [4:0]         EX_writeAddr_i,
  input  logic               EX_writeEnable_i,
  input  logic               EX_isLoad_i,
  input  logic [DATA_W-1:0]  MEM_writeData_i,
  input  logic [4:0]         MEM_writeAddr_i,
  input  logic               MEM_writeEnable_i,
  output logic               stallReq_o,
  output logic               branchEnable_o,
  output logic [DATA_W-1:0]  branchAddr_o,
  output logic               ex_valid_o,
  output logic [ALUOP_W-1:0] ex_ALUop_o,
  output logic [DATA_W-1:0]  ex_oprand1_o,
  output logic [DATA_W-1:0]  ex_oprand2_o,
  output logic [4:0]         ex_writeAddr_o,
  output logic               ex_writeEnable_o,
  output logic               ex_isLoad_o,
  output logic               ex_isDelaySlot_o,
  output logic               ex_illegal_o
);

  localparam logic [ALUOP_W-1:0] c_ALU_NOP  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] c_ALU_OR   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] c_ALU_AND  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] c_ALU_XOR  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] c_ALU_ADDU = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] c_ALU_SUBU = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] c_ALU_SLL  = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] c_ALU_SRL  = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] c_ALU_LUI  = ALUOP_W'(8);

  typedef enum logic [0:0] {
    ST_NORMAL   = 1'b0,
    ST_AFTER_BR = 1'b1
  } ds_state_t;

  typedef struct packed {
    logic               valid;
    logic [ALUOP_W-1:0] aluop;
    logic [DATA_W-1:0]  op1;
    logic [DATA_W-1:0]  op2;
    logic [4:0]         wa;
    logic               we;
    logic               load;
    logic               ds;
    logic               illegal;
  } idex_t;

  logic [5:0]         w_opcode;
  logic [5:0]         w_funct;
  logic [4:0]         w_rs;
  logic [4:0]         w_rt;
  logic [4:0]         w_rd;
  logic [DATA_W-1:0]  w_imm_zext;
  logic [DATA_W-1:0]  w_imm_sext;
  logic [DATA_W-1:0]  w_imm_lui;
  logic [DATA_W-1:0]  w_shamt;

  logic [ALUOP_W-1:0] w_aluop;
  logic               w_re1;
  logic               w_re2;
  logic [4:0]         w_wa;
  logic               w_we;
  logic               w_load;
  logic               w_shift;
  logic               w_is_j;
  logic               w_is_beq;
  logic               w_is_bne;
  logic               w_illegal;
  logic [DATA_W-1:0]  w_imm;

  logic [DATA_W-1:0]  w_rd1;
  logic [DATA_W-1:0]  w_rd2;
  logic [DATA_W-1:0]  w_op1;
  logic [DATA_W-1:0]  w_op2;
  logic               w_taken;
  logic [DATA_W-1:0]  w_target;
  logic               w_load_slot;
  idex_t              w_idex_new;
  idex_t              r_idex;
  ds_state_t          r_ds_state;
  ds_state_t          w_ds_next;

  assign w_opcode   = inst_i[31:26];
  assign w_rs       = inst_i[25:21];
  assign w_rt       = inst_i[20:16];
  assign w_rd       = inst_i[15:11];
  assign w_funct    = inst_i[5:0];
  assign w_imm_zext = DATA_W'(inst_i[15:0]);
  assign w_imm_sext = {{(DATA_W-16){inst_i[15]}}, inst_i[15:0]};
  assign w_imm_lui  = DATA_W'({inst_i[15:0], 16'h0000});
  assign w_shamt    = DATA_W'(inst_i[10:6]);

  always_comb begin
    w_aluop   = c_ALU_NOP;
    w_re1     = 1'b0;
    w_re2     = 1'b0;
    w_wa      = 5'd0;
    w_we      = 1'b0;
    w_load    = 1'b0;
    w_shift   = 1'b0;
    w_is_j    = 1'b0;
    w_is_beq  = 1'b0;
    w_is_bne  = 1'b0;
    w_illegal = 1'b0;
    w_imm     = '0;
    case (w_opcode)
      6'h0D: begin w_aluop = c_ALU_OR;   w_re1 = 1'b1; w_imm = w_imm_zext; w_wa = w_rt; w_we = 1'b1; end
      6'h0C: begin w_aluop = c_ALU_AND;  w_re1 = 1'b1; w_imm = w_imm_zext; w_wa = w_rt; w_we = 1'b1; end
      6'h0E: begin w_aluop = c_ALU_XOR;  w_re1 = 1'b1; w_imm = w_imm_zext; w_wa = w_rt; w_we = 1'b1; end
      6'h09: begin w_aluop = c_ALU_ADDU; w_re1 = 1'b1; w_imm = w_imm_sext; w_wa = w_rt; w_we = 1'b1; end
      6'h0F: begin w_aluop = c_ALU_LUI;  w_imm = w_imm_lui; w_wa = w_rt; w_we = 1'b1; end
      6'h23: begin
        w_aluop = c_ALU_ADDU; w_re1 = 1'b1; w_imm = w_imm_sext;
        w_wa = w_rt; w_we = 1'b1; w_load = 1'b1;
      end
      6'h02: w_is_j = 1'b1;
`ifdef ID_COND_BRANCH_EN
      6'h04: begin w_is_beq = 1'b1; w_re1 = 1'b1; w_re2 = 1'b1; end
      6'h05: begin w_is_bne = 1'b1; w_re1 = 1'b1; w_re2 = 1'b1; end
`endif
      6'h00: begin
        w_wa = w_rd;
        w_we = 1'b1;
        case (w_funct)
          6'h25: begin w_aluop = c_ALU_OR;   w_re1 = 1'b1; w_re2 = 1'b1; end
          6'h24: begin w_aluop = c_ALU_AND;  w_re1 = 1'b1; w_re2 = 1'b1; end
          6'h26: begin w_aluop = c_ALU_XOR;  w_re1 = 1'b1; w_re2 = 1'b1; end
          6'h21: begin w_aluop = c_ALU_ADDU; w_re1 = 1'b1; w_re2 = 1'b1; end
          6'h23: begin w_aluop = c_ALU_SUBU; w_re1 = 1'b1; w_re2 = 1'b1; end
          6'h00: begin w_aluop = c_ALU_SLL;  w_re2 = 1'b1; w_shift = 1'b1; w_imm = w_shamt; end
          6'h02: begin w_aluop = c_ALU_SRL;  w_re2 = 1'b1; w_shift = 1'b1; w_imm = w_shamt; end
          default: begin w_illegal = 1'b1; w_wa = 5'd0; w_we = 1'b0; end
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Youngest producer wins; r0 always reads as zero and is never bypassed.
  function automatic logic [DATA_W-1:0] f_operand(
    input logic [4:0]        addr,
    input logic [DATA_W-1:0] rf_data,
    input logic              ex_en,
    input logic [4:0]        ex_addr,
    input logic [DATA_W-1:0] ex_data,
    input logic              mem_en,
    input logic [4:0]        mem_addr,
    input logic [DATA_W-1:0] mem_data
  );
    if (addr == 5'd0)                        return '0;
    else if (ex_en && (ex_addr == addr))     return ex_data;
    else if (mem_en && (mem_addr == addr))   return mem_data;
    else                                     return rf_data;
  endfunction

  assign readEnable1_o = w_re1;
  assign readEnable2_o = w_re2;
  assign readAddr1_o   = w_re1 ? w_rs : 5'd0;
  assign readAddr2_o   = w_re2 ? w_rt : 5'd0;

  assign w_rd1 = f_operand(readAddr1_o, readData1_i, EX_writeEnable_i, EX_writeAddr_i, EX_writeData_i,
                           MEM_writeEnable_i, MEM_writeAddr_i, MEM_writeData_i);
  assign w_rd2 = f_operand(readAddr2_o, readData2_i, EX_writeEnable_i, EX_writeAddr_i, EX_writeData_i,
                           MEM_writeEnable_i, MEM_writeAddr_i, MEM_writeData_i);

  // Shifts take the rt value as their first operand.
  assign w_op1 = w_shift ? w_rd2 : (w_re1 ? w_rd1 : w_imm);
  assign w_op2 = (w_re2 && !w_shift) ? w_rd2 : w_imm;

  assign stallReq_o = id_valid_i && EX_isLoad_i && EX_writeEnable_i && (EX_writeAddr_i != 5'd0) &&
                      ((w_re1 && (EX_writeAddr_i == w_rs)) || (w_re2 && (EX_writeAddr_i == w_rt)));

  assign w_taken  = w_is_j || (w_is_beq && (w_rd1 == w_rd2)) || (w_is_bne && (w_rd1 != w_rd2));
  assign w_target = w_is_j ? {pc_i[DATA_W-1:28], inst_i[25:0], 2'b00}
                           : pc_i + DATA_W'(4) + (w_imm_sext << 2);

  assign branchEnable_o = id_valid_i && w_taken && !stallReq_o && !stall_i && !flush_i;
  assign branchAddr_o   = branchEnable_o ? w_target : '0;

  assign w_load_slot = id_valid_i && !stallReq_o && !w_illegal;

  always_comb begin
    w_idex_new       = '0;
    w_idex_new.valid = 1'b1;
    w_idex_new.aluop = w_aluop;
    w_idex_new.op1   = w_op1;
    w_idex_new.op2   = w_op2;
    w_idex_new.wa    = w_wa;
    w_idex_new.we    = w_we;
    w_idex_new.load  = w_load;
    w_idex_new.ds    = (r_ds_state == ST_AFTER_BR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_idex <= '0;
    else if (flush_i)                   r_idex <= '0;
    else if (stall_i)                   r_idex <= r_idex;
    else if (!id_valid_i || stallReq_o) r_idex <= '0;
    else if (w_illegal) begin
      r_idex         <= '0;
      r_idex.illegal <= 1'b1;
    end
    else                                r_idex <= w_idex_new;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ds_state <= ST_NORMAL;
    else     r_ds_state <= w_ds_next;
  end

  // Only a really loaded instruction moves the delay-slot tracker.
  always_comb begin
    w_ds_next = r_ds_state;
    if (flush_i)
      w_ds_next = ST_NORMAL;
    else if (!stall_i && w_load_slot)
      w_ds_next = (w_is_j || w_is_beq || w_is_bne) ? ST_AFTER_BR : ST_NORMAL;
  end

  assign ex_valid_o       = r_idex.valid;
  assign ex_ALUop_o       = r_idex.aluop;
  assign ex_oprand1_o     = r_idex.op1;
  assign ex_oprand2_o     = r_idex.op2;
  assign ex_writeAddr_o   = r_idex.wa;
  assign ex_writeEnable_o = r_idex.we;
  assign ex_isLoad_o      = r_idex.load;
  assign ex_isDelaySlot_o = r_idex.ds;
  assign ex_illegal_o     = r_idex.illegal;

endmodule
`default_nettype wire
